// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   GROUP_W    : width of one lookahead group (4 bits)
//   op_e       : operation select (add / subtract)
//   group_pg_t : bitwise propagate/generate plus group propagate/generate
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic               gp;
    logic               gg;
  } group_pg_t;

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group.
//   a, b : group operand bits
//   ci   : carry into the group
//   pg   : bitwise p/g and group propagate/generate
//   s    : group sum bits for the given carry-in
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               ci,
  output group_pg_t          pg,
  output logic [GROUP_W-1:0] s
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Flat sum-of-products carries inside the group.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign pg.p  = p;
  assign pg.g  = g;
  assign pg.gp = &p;
  assign pg.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

  assign s = p ^ c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshaking on both sides.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   : operand beat handshake
//   x, y, c_in, sub      : operands, carry-in (add only), subtract select
//   out_valid, out_ready : result beat handshake
//   sum, c_out           : result and carry out of MSB (borrow-not on subtract)
//   overflow, zero       : signed overflow, sum == 0
// OUT_REG=1 registers the result (latency 2); OUT_REG=0 drives the result
// combinationally from the stage-1 registers (latency 1).
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP_W;

  if ((WIDTH % GROUP_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  // Second lookahead level: each group carry is a direct sum of products of
  // the group P/G terms and the carry-in, so nothing ripples between groups.
  function automatic logic [NG:0] group_carries(input group_pg_t [NG-1:0] pg,
                                                input logic cin);
    logic [NG:0] c;
    logic        term;
    c = '0;
    for (int k = 0; k <= NG; k++) begin
      term = cin;
      for (int m = 0; m < k; m++) term = term & pg[m].gp;
      c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = pg[j].gg;
        for (int m = j + 1; m < k; m++) term = term & pg[m].gp;
        c[k] = c[k] | term;
      end
    end
    return c;
  endfunction

  // ---- stage 0 -> 1: operand conditioning and group p/g ----
  op_e                op_in;
  logic [WIDTH-1:0]   y_eff;
  group_pg_t [NG-1:0] pg_in;
  logic [WIDTH-1:0]   unused_s1;
  logic               take_in;
  logic               s2_ready;

  assign op_in   = sub ? OP_SUB : OP_ADD;
  assign y_eff   = (op_in == OP_SUB) ? ~y : y;
  assign take_in = in_valid & in_ready;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp_s1
    cla_group4 u_grp (
      .a  (x[gi*GROUP_W +: GROUP_W]),
      .b  (y_eff[gi*GROUP_W +: GROUP_W]),
      .ci (1'b0),
      .pg (pg_in[gi]),
      .s  (unused_s1[gi*GROUP_W +: GROUP_W])
    );
  end

  group_pg_t [NG-1:0] pg_p1;
  logic               cin_p1;
  op_e                op_p1;
  logic               vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  // Add-mode carry-in only; the two's-complement +1 is injected from op_p1.
  always_ff @(posedge clk) begin
    if (take_in) begin
      pg_p1  <= pg_in;
      cin_p1 <= c_in & (op_in == OP_ADD);
      op_p1  <= op_in;
    end
  end

  assign in_ready = ~vld_p1 | s2_ready;

  // ---- stage 1 -> 2: carry resolution and result flags ----
  logic [NG:0]        gc;
  logic [WIDTH-1:0]   sum_c;
  group_pg_t [NG-1:0] unused_pg2;
  logic               c_msb;
  logic               c_out_c;
  logic               ovf_c;
  logic               zero_c;

  assign gc = group_carries(pg_p1, cin_p1 | (op_p1 == OP_SUB));

  // a = p|g, b = g reproduces the original per-bit p and g exactly.
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp_s2
    cla_group4 u_grp (
      .a  (pg_p1[gi].p | pg_p1[gi].g),
      .b  (pg_p1[gi].g),
      .ci (gc[gi]),
      .pg (unused_pg2[gi]),
      .s  (sum_c[gi*GROUP_W +: GROUP_W])
    );
  end

  assign c_out_c = gc[NG];
  assign c_msb   = sum_c[WIDTH-1] ^ pg_p1[NG-1].p[GROUP_W-1];
  assign ovf_c   = c_msb ^ c_out_c;
  assign zero_c  = (sum_c == '0);

  if (OUT_REG) begin : g_out_reg
    logic             vld_p2;
    logic [WIDTH-1:0] sum_p2;
    logic             c_out_p2;
    logic             ovf_p2;
    logic             zero_p2;

    assign s2_ready = ~vld_p2 | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p2   <= 1'b0;
        sum_p2   <= '0;
        c_out_p2 <= 1'b0;
        ovf_p2   <= 1'b0;
        zero_p2  <= 1'b0;
      end else if (s2_ready) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          sum_p2   <= sum_c;
          c_out_p2 <= c_out_c;
          ovf_p2   <= ovf_c;
          zero_p2  <= zero_c;
        end
      end
    end

    assign out_valid = vld_p2;
    assign sum       = sum_p2;
    assign c_out     = c_out_p2;
    assign overflow  = ovf_p2;
    assign zero      = zero_p2;
  end else begin : g_out_comb
    // Flags are masked so an empty pipeline (and reset) reads all zeros.
    assign s2_ready  = out_ready;
    assign out_valid = vld_p1;
    assign sum       = vld_p1 ? sum_c : '0;
    assign c_out     = vld_p1 & c_out_c;
    assign overflow  = vld_p1 & ovf_c;
    assign zero      = vld_p1 & zero_c;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand width; SHALL be a multiple of 4 in 4..64, else elaboration error.
REQ-002 Parameter OUT_REG, default 1, 1 = registered output stage (latency 2), 0 = single stage (latency 1).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 x  input  WIDTH  operand A.
REQ-008 y  input  WIDTH  operand B.
REQ-009 c_in  input  1  carry-in, add mode only.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 c_out  output  1  carry out of MSB (borrow-not in subtract).
REQ-015 overflow  output  1  signed overflow.
REQ-016 zero  output  1  sum == 0.

Function
REQ-017 Add: {c_out,sum} = x + y + c_in; subtract: {c_out,sum} = x + ~y + 1, with c_in ignored.
REQ-018 Overflow SHALL equal carry into MSB XOR c_out.
REQ-019 Stage 1 SHALL register per-4-bit group propagate/generate, bitwise p/g, effective carry-in and sub flag.
REQ-020 Stage 2 SHALL resolve group carries by two-level lookahead (no ripple across groups) and produce sum, c_out, overflow and zero.
REQ-021 Stage 2 SHALL be registered when OUT_REG=1 and combinational from stage-1 registers when OUT_REG=0.
REQ-022 Beat transfer occurs when valid && ready on the same edge; each stage SHALL hold its data while its valid is high and it is not accepted.
REQ-023 in_ready = ~s1_valid | s1 advancing; the block sustains one beat per cycle with out_ready held high.
REQ-024 Latency SHALL be 2 (OUT_REG=1) or 1 (OUT_REG=0) cycles from input transfer to out_valid, with no back-pressure.
REQ-025 Under out_ready=0, no beat SHALL be lost or duplicated, and outputs SHALL remain stable while out_valid=1.
REQ-026 Simultaneous input accept and output drain on a full pipeline SHALL both occur in the same cycle.
REQ-027 Wrap-around: all-ones + 1 SHALL give sum 0, c_out 1, zero 1.
REQ-028 in_valid=0 SHALL NOT change any stage's data.

Reset
REQ-029 On rst_n low, all valid flags clear immediately; sum, c_out, overflow and zero SHALL read 0; in_ready SHALL read 1.
REQ-030 Reset mid-operation SHALL discard in-flight beats, and the first beat after release SHALL follow REQ-024 latency.
REQ-031 Data registers need no reset beyond REQ-029 outputs.

Structure
REQ-032 Shared package cla_pkg SHALL hold GROUP_W=4, the op enum (OP_ADD, OP_SUB) and the group p/g struct.
REQ-033 Sub-module cla_group4 SHALL compute 4-bit p/g, group P/G and group sum given group carry-in, instantiated WIDTH/4 times.

Verification (WIDTH=16, OUT_REG=1)
REQ-034 x=0x0003, y=0x0004, c_in=1, sub=0 -> two cycles later sum=0x0008, c_out=0, overflow=0, zero=0.
REQ-035 x=0xFFFF, y=0x0001, c_in=0, add -> sum=0x0000, c_out=1, zero=1, overflow=0; x=0x7FFF, y=0x0001 -> sum=0x8000, overflow=1.
REQ-036 x=0x0005, y=0x0007, sub=1, c_in=1 -> sum=0xFFFE, c_out=0, overflow=0; x=0x8000, y=0x0001, sub=1 -> sum=0x7FFF, overflow=1.
REQ-037 Stream of 16 beats x=i, y=i, with out_ready low on cycles 3-6 -> 16 results 2i in order, none dropped, outputs stable while stalled, in_ready low once both stages are full.
REQ-038 Exhaustive 4-bit sweep at WIDTH=4 over x, y, c_in and sub, back-to-back -> every result matches the reference model, at throughput 1 per cycle.
REQ-039 rst_n asserted with two beats in flight -> out_valid=0 asynchronously, no stale result emitted after release, and the next beat emerges after 2 cycles.
